decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/riscv_pkg.sv | 60 ++++++
 rtl/imm_gen.sv | 24 ++
 rtl/decode_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV64 decode constants, ALU control bit map and decode record types
package riscv_pkg;

    localparam int XLEN       = 64;
    localparam int ALU_CTRL_W = 17;

    // Major opcodes handled by the decode stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Bit positions inside the one-hot ALU control word
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_XOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_SLL  = 7;
    localparam int ALU_SRL  = 8;
    localparam int ALU_SRA  = 9;
    localparam int ALU_LUI  = 10;
    localparam int ALU_BEQ  = 11;
    localparam int ALU_BNE  = 12;
    localparam int ALU_BLT  = 13;
    localparam int ALU_BGE  = 14;
    localparam int ALU_BLTU = 15;
    localparam int ALU_BGEU = 16;

    // Immediate layouts understood by imm_gen; SHAMT is the zero-extended 6-bit shift amount
    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_SHAMT
    } imm_fmt_e;

    // Everything the stage hands to execute, minus the valid and illegal flags
    typedef struct packed {
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic [XLEN-1:0]       sr1;
        logic [XLEN-1:0]       sr2;
        logic [XLEN-1:0]       pc;
        logic [4:0]            rd;
        logic                  rd_we;
    } dec_t;

    // One-hot ALU control word with a single bit set
    function automatic logic [ALU_CTRL_W-1:0] alu_bit(input int idx);
        return {{(ALU_CTRL_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - immediate extraction and sign extension for the RV64 decode stage
module imm_gen
    import riscv_pkg::*;
(
    // opcode bits never contribute to an immediate, so only [31:7] is taken
    input  logic [31:7]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    // Select and sign-extend the immediate field for the requested layout
    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:     imm = {{52{instr[31]}}, instr[31:20]};
            IMM_S:     imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            IMM_SHAMT: imm = {58'b0, instr[25:20]};
            default:   imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV64 integer decode stage with one-entry output register; optional macro DECODE_ILLEGAL_TRAP_EN
module decode_stage
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       in_pc,
    output logic [4:0]            rs1_addr,
    output logic [4:0]            rs2_addr,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ALU_CTRL_W-1:0] out_alu_ctrl,
    output logic [XLEN-1:0]       out_alu_sr1,
    output logic [XLEN-1:0]       out_alu_sr2,
    output logic [XLEN-1:0]       out_pc,
    output logic [4:0]            out_rd,
    output logic                  out_rd_we,
    output logic                  out_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    imm_fmt_e        imm_fmt;
    logic [XLEN-1:0] imm;
    dec_t            dec;
    logic            legal;
    logic            capture;
    logic            out_valid_q;
    dec_t            out_q;

    assign opcode   = in_instr[6:0];
    assign rd       = in_instr[11:7];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    // A new instruction may enter whenever the output slot is empty or draining this cycle
    assign in_ready = ~out_valid_q | out_ready;
    assign capture  = in_valid & in_ready & ~flush;

    // Pick the immediate layout from the opcode alone so imm_gen does not depend on the decode result
    always_comb begin
        imm_fmt = IMM_NONE;
        case (opcode)
            OPC_OP_IMM:         imm_fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
            OPC_LOAD:           imm_fmt = IMM_I;
            OPC_STORE:          imm_fmt = IMM_S;
            OPC_LUI, OPC_AUIPC: imm_fmt = IMM_U;
            default:            imm_fmt = IMM_NONE;
        endcase
    end

    imm_gen u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (imm_fmt),
        .imm   (imm)
    );

    // Decode the incoming instruction into ALU control, operands and writeback enable
    always_comb begin
        dec    = '0;
        legal  = 1'b0;
        dec.pc = in_pc;
        dec.rd = rd;
        case (opcode)
            OPC_OP: begin
                legal = (funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
                dec.sr1   = rs1_data;
                dec.sr2   = rs2_data;
                dec.rd_we = 1'b1;
                case (funct3)
                    3'b000:  dec.alu_ctrl = alu_bit(funct7[5] ? ALU_SUB : ALU_ADD);
                    3'b001: begin
                        dec.alu_ctrl = alu_bit(ALU_SLL);
                        dec.sr2      = {58'b0, rs2_data[5:0]};
                    end
                    3'b010:  dec.alu_ctrl = alu_bit(ALU_SLT);
                    3'b011:  dec.alu_ctrl = alu_bit(ALU_SLTU);
                    3'b100:  dec.alu_ctrl = alu_bit(ALU_XOR);
                    3'b101: begin
                        dec.alu_ctrl = alu_bit(funct7[5] ? ALU_SRA : ALU_SRL);
                        dec.sr2      = {58'b0, rs2_data[5:0]};
                    end
                    3'b110:  dec.alu_ctrl = alu_bit(ALU_OR);
                    default: dec.alu_ctrl = alu_bit(ALU_AND);
                endcase
            end
            OPC_OP_IMM: begin
                legal     = 1'b1;
                dec.sr1   = rs1_data;
                dec.sr2   = imm;
                dec.rd_we = 1'b1;
                case (funct3)
                    3'b000:  dec.alu_ctrl = alu_bit(ALU_ADD);
                    3'b001: begin
                        legal        = (in_instr[31:26] == 6'b000000);
                        dec.alu_ctrl = alu_bit(ALU_SLL);
                    end
                    3'b010:  dec.alu_ctrl = alu_bit(ALU_SLT);
                    3'b011:  dec.alu_ctrl = alu_bit(ALU_SLTU);
                    3'b100:  dec.alu_ctrl = alu_bit(ALU_XOR);
                    3'b101: begin
                        legal        = (in_instr[31:26] == 6'b000000) || (in_instr[31:26] == 6'b010000);
                        dec.alu_ctrl = alu_bit(in_instr[30] ? ALU_SRA : ALU_SRL);
                    end
                    3'b110:  dec.alu_ctrl = alu_bit(ALU_OR);
                    default: dec.alu_ctrl = alu_bit(ALU_AND);
                endcase
            end
            OPC_LUI: begin
                legal        = 1'b1;
                dec.alu_ctrl = alu_bit(ALU_LUI);
                dec.sr2      = imm;
                dec.rd_we    = 1'b1;
            end
            OPC_AUIPC: begin
                legal        = 1'b1;
                dec.alu_ctrl = alu_bit(ALU_ADD);
                dec.sr1      = in_pc;
                dec.sr2      = imm;
                dec.rd_we    = 1'b1;
            end
            OPC_LOAD: begin
                // funct3 111 has no RV64 load
                legal        = (funct3 != 3'b111);
                dec.alu_ctrl = alu_bit(ALU_ADD);
                dec.sr1      = rs1_data;
                dec.sr2      = imm;
                dec.rd_we    = 1'b1;
            end
            OPC_STORE: begin
                legal        = ~funct3[2];
                dec.alu_ctrl = alu_bit(ALU_ADD);
                dec.sr1      = rs1_data;
                dec.sr2      = imm;
            end
            OPC_BRANCH: begin
                legal   = 1'b1;
                dec.sr1 = rs1_data;
                dec.sr2 = rs2_data;
                case (funct3)
                    3'b000:  dec.alu_ctrl = alu_bit(ALU_BEQ);
                    3'b001:  dec.alu_ctrl = alu_bit(ALU_BNE);
                    3'b100:  dec.alu_ctrl = alu_bit(ALU_BLT);
                    3'b101:  dec.alu_ctrl = alu_bit(ALU_BGE);
                    3'b110:  dec.alu_ctrl = alu_bit(ALU_BLTU);
                    3'b111:  dec.alu_ctrl = alu_bit(ALU_BGEU);
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        // Unknown encodings travel down the pipe as a harmless bubble
        if (!legal) begin
            dec.alu_ctrl = '0;
            dec.sr1      = '0;
            dec.sr2      = '0;
            dec.rd_we    = 1'b0;
        end
        // x0 is never written
        if (rd == 5'd0) begin
            dec.rd_we = 1'b0;
        end
    end

    // Output slot: load on accept, hold while stalled, empty on drain or flush
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (capture) begin
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (capture) begin
                out_q <= dec;
            end
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic out_illegal_q;

    // Illegal flag travels with the instruction it describes
    always_ff @(posedge clk) begin
        if (rst) begin
            out_illegal_q <= 1'b0;
        end else if (capture) begin
            out_illegal_q <= ~legal;
        end
    end

    assign out_illegal = out_illegal_q;
`else
    assign out_illegal = 1'b0;
`endif

    assign out_valid    = out_valid_q;
    assign out_alu_ctrl = out_q.alu_ctrl;
    assign out_alu_sr1  = out_q.sr1;
    assign out_alu_sr2  = out_q.sr2;
    assign out_pc       = out_q.pc;
    assign out_rd       = out_q.rd;
    assign out_rd_we    = out_q.rd_we;

endmodule
